// File: rtl/bitmask_set_bit_iterator_pkg.sv
// Shared types and helpers for the set-bit iterator.
// Holds the FSM state encoding and an elaboration-time clog2.
package bitmask_set_bit_iterator_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/bitmask_set_bit_iterator_isolate.sv
// Isolates the lowest set bit of a word (x & -x).
// Yields all-zero when the word is all-zero.
module Bitmask_Isolate_Rightmost_1_Bit #(
  parameter int WORD_WIDTH = 8
) (
  input  logic [WORD_WIDTH-1:0] i_word,
  output logic [WORD_WIDTH-1:0] o_bit
);

  logic [WORD_WIDTH-1:0] w_neg;

  assign w_neg = ~i_word + WORD_WIDTH'(1);
  assign o_bit = i_word & w_neg;

endmodule

// File: rtl/bitmask_set_bit_iterator.sv
// Serialises a bitmask into one-hot beats with index, one per cycle.
// LSB-first by default; MSB_FIRST reverses the scan order.
module bitmask_set_bit_iterator
  import bitmask_set_bit_iterator_pkg::*;
#(
  parameter int WORD_WIDTH = 8,
  parameter bit MSB_FIRST  = 1'b0,
  localparam int INDEX_WIDTH = clog2(WORD_WIDTH)
) (
  input  logic                   clock,
  input  logic                   clear,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WORD_WIDTH-1:0]  word_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WORD_WIDTH-1:0]  out_onehot,
  output logic [INDEX_WIDTH-1:0] out_index,
  output logic                   out_last,
  output logic                   out_empty
);

  state_e r_state;
  state_e w_state_nxt;

  logic [WORD_WIDTH-1:0] r_residue;
  logic [WORD_WIDTH-1:0] w_residue_nxt;
  logic                  r_empty;
  logic                  w_empty_nxt;

  logic [WORD_WIDTH-1:0] w_scan;
  logic [WORD_WIDTH-1:0] w_iso;
  logic [WORD_WIDTH-1:0] w_onehot;
  logic [WORD_WIDTH-1:0] w_rest;
  logic [INDEX_WIDTH-1:0] w_index;

  logic w_busy;
  logic w_last;
  logic w_advance;
  logic w_retire;
  logic w_load;

  // MSB mode scans a reversed copy so one isolator serves both orders.
  for (genvar g = 0; g < WORD_WIDTH; g++) begin : g_order
    if (MSB_FIRST) begin : g_rev
      assign w_scan[g]   = r_residue[WORD_WIDTH-1-g];
      assign w_onehot[g] = w_iso[WORD_WIDTH-1-g];
    end else begin : g_fwd
      assign w_scan[g]   = r_residue[g];
      assign w_onehot[g] = w_iso[g];
    end
  end

  Bitmask_Isolate_Rightmost_1_Bit #(
    .WORD_WIDTH(WORD_WIDTH)
  ) u_isolate (
    .i_word(w_scan),
    .o_bit (w_iso)
  );

  always_comb begin
    w_index = '0;
    for (int i = 0; i < WORD_WIDTH; i++) begin
      if (w_onehot[i]) begin
        w_index = w_index | INDEX_WIDTH'(i);
      end
    end
  end

  assign w_rest    = r_residue & ~w_onehot;
  assign w_last    = (w_rest == '0);
  assign w_busy    = (r_state == ST_BUSY);
  assign w_advance = w_busy && out_ready;
  assign w_retire  = w_advance && w_last;
  assign in_ready  = !w_busy || w_retire;
  assign w_load    = in_valid && in_ready;

  always_comb begin
    w_state_nxt   = r_state;
    w_residue_nxt = r_residue;
    w_empty_nxt   = r_empty;
    if (w_load) begin
      w_state_nxt   = ST_BUSY;
      w_residue_nxt = word_in;
      w_empty_nxt   = (word_in == '0);
    end else if (w_advance) begin
      w_residue_nxt = w_rest;
      if (w_last) begin
        w_state_nxt = ST_IDLE;
        w_empty_nxt = 1'b0;
      end
    end
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      r_state   <= ST_IDLE;
      r_residue <= '0;
      r_empty   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_residue <= w_residue_nxt;
      r_empty   <= w_empty_nxt;
    end
  end

  assign out_valid  = w_busy;
  assign out_onehot = w_busy ? w_onehot : '0;
  assign out_index  = w_busy ? w_index : '0;
  assign out_last   = w_busy && w_last;
  assign out_empty  = w_busy && r_empty;

endmodule

// File: tb/tb_bitmask_set_bit_iterator.sv
// Bench for the set-bit iterator: LSB and MSB instances share stimulus
// and are compared against per-word beat lists built from the mask.
module tb_bitmask_set_bit_iterator;

  typedef struct packed {
    logic [7:0] oh;
    logic [2:0] idx;
    logic       last;
    logic       empty;
  } beat_t;

  logic       clock;
  logic       clear;
  logic       in_valid;
  logic [7:0] word_in;
  logic       out_ready;

  logic       ir_l, ov_l, ol_l, oe_l;
  logic [7:0] oh_l;
  logic [2:0] ix_l;
  logic       ir_m, ov_m, ol_m, oe_m;
  logic [7:0] oh_m;
  logic [2:0] ix_m;

  int n_tests = 0;
  int n_fail  = 0;

  beat_t q_lsb[$];
  beat_t q_msb[$];
  bit    last_acc = 1'b0;

  bitmask_set_bit_iterator #(
    .WORD_WIDTH(8),
    .MSB_FIRST (1'b0)
  ) u_lsb (
    .clock     (clock),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (ir_l),
    .word_in   (word_in),
    .out_valid (ov_l),
    .out_ready (out_ready),
    .out_onehot(oh_l),
    .out_index (ix_l),
    .out_last  (ol_l),
    .out_empty (oe_l)
  );

  bitmask_set_bit_iterator #(
    .WORD_WIDTH(8),
    .MSB_FIRST (1'b1)
  ) u_msb (
    .clock     (clock),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (ir_m),
    .word_in   (word_in),
    .out_valid (ov_m),
    .out_ready (out_ready),
    .out_onehot(oh_m),
    .out_index (ix_m),
    .out_last  (ol_m),
    .out_empty (oe_m)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_dut(input string p, input bit has, input beat_t e,
                           input logic ov, input logic [7:0] oh,
                           input logic [2:0] ix, input logic ol,
                           input logic oe);
    if (has) begin
      check({p, "_valid"}, ov, 1);
      check({p, "_onehot"}, oh, e.oh);
      check({p, "_index"}, ix, e.idx);
      check({p, "_last"}, ol, e.last);
      check({p, "_empty"}, oe, e.empty);
    end else begin
      check({p, "_valid"}, ov, 0);
      check({p, "_onehot"}, oh, 0);
      check({p, "_index"}, ix, 0);
      check({p, "_last"}, ol, 0);
      check({p, "_empty"}, oe, 0);
    end
  endtask

  // Expected beats of a word: its set bits in scan order, or one empty beat.
  task automatic push_word(input logic [7:0] w);
    int    k;
    int    n;
    beat_t b;
    k = $countones(w);
    if (w == 8'h00) begin
      b = '{oh: 8'h00, idx: 3'd0, last: 1'b1, empty: 1'b1};
      q_lsb.push_back(b);
      q_msb.push_back(b);
    end else begin
      n = 0;
      for (int i = 0; i < 8; i++) begin
        if (w[i]) begin
          n++;
          b = '{oh: 8'(1 << i), idx: 3'(i), last: (n == k), empty: 1'b0};
          q_lsb.push_back(b);
        end
      end
      n = 0;
      for (int i = 7; i >= 0; i--) begin
        if (w[i]) begin
          n++;
          b = '{oh: 8'(1 << i), idx: 3'(i), last: (n == k), empty: 1'b0};
          q_msb.push_back(b);
        end
      end
    end
  endtask

  task automatic step(input logic iv, input logic [7:0] w,
                      input logic ordy);
    bit    exp_ir;
    bit    acc;
    beat_t hl;
    beat_t hm;
    @(negedge clock);
    in_valid  = iv;
    word_in   = w;
    out_ready = ordy;
    #1;
    hl = (q_lsb.size() > 0) ? q_lsb[0] : '0;
    hm = (q_msb.size() > 0) ? q_msb[0] : '0;
    check_dut("lsb", q_lsb.size() > 0, hl, ov_l, oh_l, ix_l, ol_l, oe_l);
    check_dut("msb", q_msb.size() > 0, hm, ov_m, oh_m, ix_m, ol_m, oe_m);
    exp_ir = (q_lsb.size() == 0) || (q_lsb.size() == 1 && ordy);
    check("lsb_in_ready", ir_l, exp_ir);
    check("msb_in_ready", ir_m, exp_ir);
    acc = iv && exp_ir;
    if (ordy && q_lsb.size() > 0) begin
      void'(q_lsb.pop_front());
      void'(q_msb.pop_front());
    end
    if (acc) push_word(w);
    last_acc = acc;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b1);
  endtask

  initial begin
    logic       cur_iv;
    logic [7:0] cur_w;
    int         r;

    clear     = 1'b1;
    in_valid  = 1'b0;
    word_in   = 8'h00;
    out_ready = 1'b0;
    #1;
    check_dut("rst_lsb", 1'b0, '0, ov_l, oh_l, ix_l, ol_l, oe_l);
    check_dut("rst_msb", 1'b0, '0, ov_m, oh_m, ix_m, ol_m, oe_m);
    repeat (2) @(posedge clock);
    #2 clear = 1'b0;

    // Mixed bits in both orders, then trailing idle cycles.
    step(1'b1, 8'h58, 1'b1);
    drain(4);
    // Empty word gives exactly one beat.
    step(1'b1, 8'h00, 1'b1);
    drain(2);
    // Stalled beat must stay stable.
    step(1'b1, 8'h81, 1'b1);
    repeat (5) step(1'b0, 8'h00, 1'b0);
    drain(3);
    // Second word held until the last beat of the first retires.
    step(1'b1, 8'h03, 1'b1);
    step(1'b1, 8'h04, 1'b1);
    step(1'b1, 8'h04, 1'b1);
    drain(3);
    // Full word.
    step(1'b1, 8'hFF, 1'b1);
    drain(10);

    // Clear mid-word drops the stream asynchronously.
    step(1'b1, 8'hFF, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    @(negedge clock);
    clear = 1'b1;
    #1;
    check("clr_lsb_valid", ov_l, 0);
    check("clr_msb_valid", ov_m, 0);
    q_lsb.delete();
    q_msb.delete();
    #3 clear = 1'b0;
    drain(2);
    step(1'b1, 8'h20, 1'b1);
    drain(3);

    // Random traffic; upstream holds an unaccepted word.
    cur_iv = 1'b0;
    cur_w  = 8'h00;
    for (int i = 0; i < 600; i++) begin
      if (!(cur_iv && !last_acc)) begin
        cur_iv = ($urandom_range(0, 2) != 0);
        r = $urandom_range(0, 9);
        if (r == 0)      cur_w = 8'h00;
        else if (r == 1) cur_w = 8'hFF;
        else             cur_w = 8'($urandom);
      end
      step(cur_iv, cur_w, ($urandom_range(0, 3) != 0));
    end
    drain(12);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
